// File: rtl/maximas_tx_pkg.sv
// Shared types, sync bytes, FSM encoding and frame sizing for the maxima UART sender.
// Frame length depends on MAXIMAS_TX_CHECKSUM_EN (adds one trailing XOR byte when defined).
package maximas_tx_pkg;

   typedef logic [24:0] maxima_t;

   localparam logic [7:0] SYNC0 = 8'hA5;
   localparam logic [7:0] SYNC1 = 8'h5A;

   // Wide enough for frames of up to 63 maxima words.
   localparam int BYTE_IDX_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } tx_state_t;

   function automatic int frame_bytes(input int num_maximas);
`ifdef MAXIMAS_TX_CHECKSUM_EN
      return 3 + 4 * num_maximas + 1;
`else
      return 3 + 4 * num_maximas;
`endif
   endfunction

   function automatic logic [7:0] payload_xor(input maxima_t m);
      return {7'b0, m[24]} ^ m[23:16] ^ m[15:8] ^ m[7:0];
   endfunction

endpackage

// File: rtl/maximas_uart_tx_if.sv
// Bundle between the peak finder, the maxima UART sender and the board pin.
interface maximas_uart_tx_if #(
   parameter int NUM_MAXIMAS = 16
);

   maximas_tx_pkg::maxima_t [NUM_MAXIMAS-1:0] maximas;
   logic                                       maximas_found_active;
   logic                                       tx;
   logic                                       busy;
   logic                                       frame_done;
   logic [7:0]                                 dropped_frames;

   modport master (
      output maximas, maximas_found_active,
      input  tx, busy, frame_done, dropped_frames
   );

   modport slave (
      input  maximas, maximas_found_active,
      output tx, busy, frame_done, dropped_frames
   );

endinterface

// File: rtl/maximas_uart_tx_byte.sv
// One 8N1 byte on a registered tx line; start accepted while ready, tx changes one edge later.
// Ready in the last STOP cycle lets the next byte follow with no idle gap.
module uart_tx_byte
   import maximas_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data,
   input  logic       start,
   output logic       ready,
   output logic       tx
);

   localparam int            BW        = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);

   tx_state_t     state, state_d;
   logic [BW-1:0] baud, baud_d;
   logic [2:0]    bit_cnt, bit_cnt_d;
   logic [7:0]    shreg, shreg_d;
   logic          tx_d;
   logic          bit_end;

   assign bit_end = (baud == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         baud    <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         tx      <= 1'b1;
      end else begin
         state   <= state_d;
         baud    <= baud_d;
         bit_cnt <= bit_cnt_d;
         shreg   <= shreg_d;
         tx      <= tx_d;
      end
   end

   always_comb begin
      state_d   = state;
      baud_d    = baud;
      bit_cnt_d = bit_cnt;
      shreg_d   = shreg;
      if (state != ST_IDLE) baud_d = bit_end ? BAUD_LOAD : baud - BW'(1);
      case (state)
         ST_IDLE: if (start) begin
            state_d = ST_START;
            baud_d  = BAUD_LOAD;
            shreg_d = data;
         end
         ST_START: if (bit_end) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
         end
         ST_DATA: if (bit_end) begin
            if (bit_cnt == 3'd7) begin
               state_d = ST_STOP;
            end else begin
               bit_cnt_d = bit_cnt + 3'd1;
               shreg_d   = shreg >> 1;
            end
         end
         ST_STOP: if (bit_end) begin
            if (start) begin
               state_d = ST_START;
               shreg_d = data;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // tx is decoded from the next state so the pin itself is a flop output.
   always_comb begin
      ready = (state == ST_IDLE) || ((state == ST_STOP) && bit_end);
      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shreg_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

endmodule

// File: rtl/maximas_uart_tx.sv
// Snapshots the maxima set and streams it as A5 5A seq payload [XOR, if MAXIMAS_TX_CHECKSUM_EN] over UART 8N1.
// tx falls one edge after capture; pulses arriving while busy are dropped and counted (saturating).
module maximas_uart_tx
   import maximas_tx_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BAUD        = 115_200,
   parameter int NUM_MAXIMAS = 16
) (
   input logic              clk,
   input logic              reset,
   maximas_uart_tx_if.slave bus
);

   localparam int              CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
   localparam int              FB           = frame_bytes(NUM_MAXIMAS);
   localparam int              IW           = BYTE_IDX_W;
   localparam int              KW           = $clog2(NUM_MAXIMAS);
   localparam logic [IW-1:0]   LAST_IDX     = IW'(FB - 1);

   maxima_t [NUM_MAXIMAS-1:0] shadow;
   logic                      busy;
   logic                      more;
   logic [IW-1:0]             byte_idx;
   logic [7:0]                seq;
   logic                      frame_done;
   logic [7:0]                dropped;
   logic                      byte_rdy;
   logic [7:0]                tx_byte;
   logic [IW-1:0]             pay_idx;
   maxima_t                   cur;
   logic [7:0]                pay_byte;
`ifdef MAXIMAS_TX_CHECKSUM_EN
   logic [7:0]                chk;
   logic [7:0]                cap_xor;

   always_comb begin
      cap_xor = '0;
      for (int k = 0; k < NUM_MAXIMAS; k++) cap_xor ^= payload_xor(bus.maximas[k]);
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shadow     <= '0;
         busy       <= 1'b0;
         more       <= 1'b0;
         byte_idx   <= '0;
         seq        <= '0;
         frame_done <= 1'b0;
         dropped    <= '0;
`ifdef MAXIMAS_TX_CHECKSUM_EN
         chk        <= '0;
`endif
      end else begin
         frame_done <= 1'b0;
         if (bus.maximas_found_active && !busy) begin
            shadow   <= bus.maximas;
            busy     <= 1'b1;
            more     <= 1'b1;
            byte_idx <= '0;
`ifdef MAXIMAS_TX_CHECKSUM_EN
            chk      <= seq ^ cap_xor;
`endif
         end else if (bus.maximas_found_active && (dropped != 8'hFF)) begin
            dropped <= dropped + 8'd1;
         end
         if (busy && more && byte_rdy) begin
            if (byte_idx == LAST_IDX) more <= 1'b0;
            else                      byte_idx <= byte_idx + IW'(1);
         end
         // Last byte handed over and its stop bit just finished.
         if (busy && !more && byte_rdy) begin
            busy       <= 1'b0;
            frame_done <= 1'b1;
            seq        <= seq + 8'd1;
         end
      end
   end

   always_comb begin
      pay_idx = byte_idx - IW'(3);
      cur     = shadow[KW'(pay_idx >> 2)];
      case (pay_idx[1:0])
         2'd0:    pay_byte = {7'b0, cur[24]};
         2'd1:    pay_byte = cur[23:16];
         2'd2:    pay_byte = cur[15:8];
         default: pay_byte = cur[7:0];
      endcase
      if      (byte_idx == IW'(0)) tx_byte = SYNC0;
      else if (byte_idx == IW'(1)) tx_byte = SYNC1;
      else if (byte_idx == IW'(2)) tx_byte = seq;
`ifdef MAXIMAS_TX_CHECKSUM_EN
      else if (byte_idx == LAST_IDX) tx_byte = chk;
`endif
      else                         tx_byte = pay_byte;
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte (
      .clk   (clk),
      .reset (reset),
      .data  (tx_byte),
      .start (more),
      .ready (byte_rdy),
      .tx    (bus.tx)
   );

   assign bus.busy           = busy;
   assign bus.frame_done     = frame_done;
   assign bus.dropped_frames = dropped;

endmodule
